// File: rtl/arm_cmd_sequencer_pkg.sv
// Shared definitions for the Arm command sequencer: id width, the "no id"
// value driven on in_id between issues, FSM encoding and the request struct
// carried through the request FIFO.
package arm_pkg;

  localparam int                ARM_ID_W    = 8;
  localparam logic [ARM_ID_W-1:0] ARM_ID_NONE = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP
  } arm_state_e;

  typedef struct packed {
    logic [ARM_ID_W-1:0] id;
    logic                cmd;
  } arm_req_t;

  localparam int ARM_REQ_W = $bits(arm_req_t);

endpackage

// File: rtl/arm_req_fifo.sv
// Synchronous request FIFO with fall-through read data.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   wr_en_i/wr_data_i write strobe and data (ignored while full)
//   rd_en_i           pop strobe (ignored while empty); rd_data_o shows the head
//   full_o, empty_o   occupancy flags decoded from the entry counter
//   count_o           number of stored entries
module arm_req_fifo #(
  parameter  int DEPTH = 4,   // power of 2, >= 2
  parameter  int WIDTH = 9,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_wr, do_rd;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign count_o   = count_q;
  assign do_wr     = wr_en_i & ~full_o;
  assign do_rd     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Pointers are exactly log2(DEPTH) wide, so they wrap on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; the counter alone defines which entries are valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/arm_cmd_sequencer.sv
// Feeds the Arm UART frame transmitter: buffers {id, cmd} requests, issues
// each one as a single-cycle in_id pulse with in_cmd held, waits for the
// Tx_Done rising edge (or a timeout), then enforces an idle gap before the
// next issue.
// Ports:
//   Clk, Rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake; req_id (0 = illegal), req_cmd
//   Tx_Done                   frame-complete level from Arm
//   in_id, in_cmd             to Arm: id pulse per issue, cmd held between issues
//   busy                      sequencer active or requests pending
//   fifo_count                stored requests
//   bad_id, timeout_err       single-cycle error pulses
module arm_cmd_sequencer
  import arm_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [ARM_ID_W-1:0]            req_id,
  input  logic                           req_cmd,
  input  logic                           Tx_Done,
  output logic [ARM_ID_W-1:0]            in_id,
  output logic                           in_cmd,
  output logic                           busy,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
  output logic                           bad_id,
  output logic                           timeout_err
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  arm_state_e          state_q, state_d;
  arm_req_t            cur_q, cur_d, head, wr_req;
  logic [TO_W-1:0]     to_q, to_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic [ARM_ID_W-1:0] in_id_q, in_id_d;
  logic                in_cmd_q, in_cmd_d;
  logic                timeout_q, timeout_d;
  logic                bad_q, txd_q, done_rise;
  logic                push, pop, full, empty;
  logic [ARM_REQ_W-1:0] rd_data;

  // Ready is a decode of the registered entry count, so a pop in the same
  // cycle never lets a push into a full FIFO.
  assign req_ready = ~full;
  assign push      = req_valid & req_ready;
  assign wr_req    = '{id: req_id, cmd: req_cmd};
  assign head      = arm_req_t'(rd_data);
  assign done_rise = Tx_Done & ~txd_q;

  arm_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ARM_REQ_W)
  ) u_fifo (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .wr_en_i   (push & (req_id != ARM_ID_NONE)),
    .wr_data_i (wr_req),
    .rd_en_i   (pop),
    .rd_data_o (rd_data),
    .full_o    (full),
    .empty_o   (empty),
    .count_o   (fifo_count)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      cur_q     <= '0;
      to_q      <= '0;
      gap_q     <= '0;
      in_id_q   <= ARM_ID_NONE;
      in_cmd_q  <= 1'b0;
      timeout_q <= 1'b0;
      bad_q     <= 1'b0;
      txd_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      to_q      <= to_d;
      gap_q     <= gap_d;
      in_id_q   <= in_id_d;
      in_cmd_q  <= in_cmd_d;
      timeout_q <= timeout_d;
      bad_q     <= push & (req_id == ARM_ID_NONE);
      txd_q     <= Tx_Done;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    to_d      = to_q;
    gap_d     = gap_q;
    in_id_d   = ARM_ID_NONE;
    in_cmd_d  = in_cmd_q;
    timeout_d = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cur_d   = head;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        in_id_d  = cur_q.id;
        in_cmd_d = cur_q.cmd;
        to_d     = '0;
        state_d  = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // Checked before the timeout so a coincident done is not an error.
        if (done_rise) begin
          gap_d   = '0;
          state_d = S_GAP;
        end else if (to_q == TO_LAST) begin
          timeout_d = 1'b1;
          gap_d     = '0;
          state_d   = S_GAP;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_id       = in_id_q;
  assign in_cmd      = in_cmd_q;
  assign bad_id      = bad_q;
  assign timeout_err = timeout_q;
  assign busy        = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_arm_cmd_sequencer.sv
// Randomized + directed bench for arm_cmd_sequencer with a scoreboard.
// Stimulus pushes expected issues / error pulses into queues; the monitor,
// which also models the Arm side (Tx_Done after a chosen delay), pops and
// compares whenever the DUT presents a pulse.
module tb_arm_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int GAP   = 40;
  localparam int TO    = 200;

  logic       Clk = 1'b0, Rst = 1'b1;
  logic       req_valid = 1'b0, req_cmd = 1'b0;
  logic [7:0] req_id = 8'h00;
  logic       req_ready, in_cmd, busy, bad_id, timeout_err, Tx_Done;
  logic [7:0] in_id;
  logic [2:0] fifo_count;
  logic       arm_done = 1'b0, man_done = 1'b0;

  assign Tx_Done = arm_done | man_done;

  arm_cmd_sequencer #(
    .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .Clk(Clk), .Rst(Rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_cmd(req_cmd), .Tx_Done(Tx_Done), .in_id(in_id),
    .in_cmd(in_cmd), .busy(busy), .fifo_count(fifo_count), .bad_id(bad_id),
    .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct { logic [7:0] id; logic cmd; int acc; } exp_t;
  exp_t sbq[$];
  int   bq[$], tq[$];

  int   checks = 0, errors = 0;
  int   next_min = 0;     // earliest legal next issue, from the last frame end
  logic last_cmd = 1'b0;
  bit   mon_en = 1'b0, arm_rand = 1'b0, prev_nz = 1'b0, exp_b, exp_t_;
  int   arm_delay = 25, done_at = -1, d, iss_exp, fend;
  exp_t me;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)  return $urandom_range(1, 60);
    if (r == 6) return TO - 1;   // done lands on the timeout cycle
    if (r == 7) return TO;       // one cycle too late
    if (r == 8) return TO + 10;
    return $urandom_range(61, TO - 2);
  endfunction

  // Monitor + Arm model. Pulses are visible at the negedge whose cyc equals
  // the edge that produced them.
  always @(negedge Clk) begin
    if (!mon_en) begin
      arm_done = 1'b0;
      done_at  = -1;
      prev_nz  = 1'b0;
    end else begin
      if (done_at >= 0 && cyc == done_at) arm_done = 1'b1;
      if (done_at >= 0 && cyc == done_at + 3) begin
        arm_done = 1'b0;
        done_at  = -1;
      end
      if (in_id != 8'h00) begin
        chk("in_id_width", int'(prev_nz), 0);
        if (sbq.size() == 0) chk("unexpected_issue", int'(in_id), 0);
        else begin
          me = sbq.pop_front();
          chk("issue_id", int'(in_id), int'(me.id));
          chk("issue_cmd", int'(in_cmd), int'(me.cmd));
          iss_exp = (next_min > me.acc + 2) ? next_min : me.acc + 2;
          chk("issue_cycle", cyc, iss_exp);
          d       = arm_rand ? pick_delay() : arm_delay;
          done_at = cyc + d;
          // Tx_Done raised at negedge cyc+d is seen rising at edge cyc+d+1;
          // WAIT_DONE gives up at edge cyc+TO.
          fend = cyc + ((d + 1 < TO) ? d + 1 : TO);
          if (d + 1 > TO) tq.push_back(cyc + TO);
          next_min = fend + GAP + 2;
          last_cmd = me.cmd;
        end
      end
      prev_nz = (in_id != 8'h00);
      chk("in_cmd_hold", int'(in_cmd), int'(last_cmd));
      exp_b = (bq.size() > 0 && bq[0] == cyc);
      if (exp_b) void'(bq.pop_front());
      chk("bad_id", int'(bad_id), int'(exp_b));
      exp_t_ = (tq.size() > 0 && tq[0] == cyc);
      if (exp_t_) void'(tq.pop_front());
      chk("timeout_err", int'(timeout_err), int'(exp_t_));
    end
  end

  // Called at a negedge; returns at the negedge of the accepting edge.
  task automatic push(input logic [7:0] id, input logic cmd);
    int n = 0;
    req_valid = 1'b1; req_id = id; req_cmd = cmd;
    while (!req_ready && n < 3000) begin @(negedge Clk); n++; end
    if (!req_ready) chk("push_accept_timeout", 0, 1);
    else if (id == 8'h00) bq.push_back(cyc + 1);
    else sbq.push_back(exp_t'{id: id, cmd: cmd, acc: cyc + 1});
    @(negedge Clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_sb(input int n);
    int k = 0;
    while (sbq.size() > n && k < 3000) begin @(negedge Clk); k++; end
    if (sbq.size() > n) chk("wait_issue_timeout", sbq.size(), n);
  endtask

  // Waits for the model's idle point and checks busy drops exactly there.
  task automatic wait_idle();
    int k = 0;
    while ((sbq.size() != 0 || cyc < next_min - 2) && k < 5000) begin
      if (sbq.size() == 0 && cyc == next_min - 3) chk("busy_in_gap", int'(busy), 1);
      @(negedge Clk); k++;
    end
    if (k >= 5000) chk("wait_idle_timeout", k, 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    int nz;
    repeat (3) @(negedge Clk);
    chk("rst_in_id", int'(in_id), 0);
    chk("rst_in_cmd", int'(in_cmd), 0);
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_bad_id", int'(bad_id), 0);
    chk("rst_timeout_err", int'(timeout_err), 0);
    Rst = 1'b0; mon_en = 1'b1;
    @(negedge Clk);

    // single request
    push(8'h02, 1'b1);
    chk("cnt_after_push", int'(fifo_count), 1);
    wait_idle();

    // three back-to-back
    push(8'h02, 1'b1); push(8'h09, 1'b0); push(8'h02, 1'b0);
    wait_idle();

    // fill while WAIT_DONE is stalled; done lands on the last timeout cycle
    arm_delay = TO - 1;
    push(8'h11, 1'b0);
    wait_sb(0);
    push(8'h21, 1'b1); push(8'h22, 1'b0); push(8'h23, 1'b1); push(8'h24, 1'b0);
    chk("cnt_full", int'(fifo_count), 4);
    chk("ready_full", int'(req_ready), 0);
    push(8'h25, 1'b1);
    chk("cnt_refill", int'(fifo_count), 4);
    wait_idle();

    // illegal id
    arm_delay = 25;
    push(8'h00, 1'b1);
    chk("cnt_bad", int'(fifo_count), 0);
    repeat (5) @(negedge Clk);
    chk("busy_bad", int'(busy), 0);

    // timeout then a queued request
    arm_delay = TO + 5;
    push(8'h31, 1'b1); push(8'h32, 1'b0);
    wait_sb(1);
    arm_delay = 25;
    wait_idle();

    // randomized
    arm_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge Clk);
      push(($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
           1'($urandom_range(0, 1)));
    end
    wait_idle();
    arm_rand = 1'b0;

    // reset during GAP with two requests queued
    arm_delay = 10;
    push(8'h41, 1'b1); push(8'h42, 1'b0); push(8'h43, 1'b1);
    wait_sb(2);
    repeat (20) @(negedge Clk);
    mon_en = 1'b0;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    sbq.delete(); bq.delete(); tq.delete();
    chk("rst_gap_fifo_count", int'(fifo_count), 0);
    chk("rst_gap_in_cmd", int'(in_cmd), 0);
    chk("rst_gap_busy", int'(busy), 0);
    chk("rst_gap_ready", int'(req_ready), 1);
    man_done = 1'b1;
    repeat (3) @(negedge Clk);
    man_done = 1'b0;
    nz = 0;
    repeat (100) begin
      @(negedge Clk);
      if (in_id != 8'h00) nz++;
    end
    chk("no_issue_after_rst", nz, 0);
    chk("busy_after_rst", int'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arm_cmd_sequencer.md
Name: arm_cmd_sequencer

Overview:
Upstream feeder for the Arm UART frame transmitter.
- Accepts arm action requests (servo group id, command bit) from control logic through a valid/ready interface and buffers them in a small FIFO.
- Issues each request to Arm as the one-cycle in_id pulse plus a held in_cmd level that Arm expects.
- Waits for Arm's Tx_Done, then enforces an inter-frame gap before issuing the next request. No request is lost or overlaps a frame in flight.

Parameters:
FIFO_DEPTH, 4, request buffer entries; power of 2, minimum 2
GAP_CYCLES, 1000, idle Clk cycles after Tx_Done before the next issue (20 us at 50 MHz)
TIMEOUT_CYCLES, 200000, maximum Clk cycles to wait for Tx_Done before abandoning a frame

Ports:
Clk  input  1  system clock
Rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid & req_ready
req_id  input  8  servo group id; 0 is illegal
req_cmd  input  1  command bit for this id
Tx_Done  input  1  frame-complete flag from Arm
in_id  output  8  to Arm: id for exactly one cycle per issue, 8'h00 otherwise
in_cmd  output  1  to Arm: command of the most recent issue, held until the next issue
busy  output  1  FSM not IDLE or FIFO not empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries stored
bad_id  output  1  one-cycle pulse: request with req_id==0 consumed and dropped
timeout_err  output  1  one-cycle pulse: Tx_Done not seen within TIMEOUT_CYCLES

Behaviour:
- One clock, Clk. Reset is synchronous and active-high (Rst). All state changes happen on posedge Clk.
- Reset values: in_id=0, in_cmd=0, req_ready=1, busy=0, fifo_count=0, bad_id=0, timeout_err=0. FSM=IDLE, FIFO pointers=0, counters=0, Tx_Done edge register=0.
- Reset mid-frame: everything returns to reset values in the next cycle. The queued contents are discarded. The Arm frame already in flight is not aborted; its later Tx_Done is ignored because the FSM is in IDLE.
- req_ready = (fifo_count != FIFO_DEPTH), registered.
- Push with req_id != 0: the {id, cmd} pair is written.
- Push with req_id == 0: the request is consumed without being stored, and bad_id pulses in the next cycle.
- Push while full: not accepted, even if a pop occurs in the same cycle.
- Push and pop in the same non-full cycle: fifo_count is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Tx_Done is used as a rising edge: done_rise = Tx_Done & ~Tx_Done_q.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and go to ISSUE.
  - ISSUE (1 cycle): in_id = popped id and in_cmd = popped cmd, both registered outputs. Next state is WAIT_DONE; in_id returns to 0.
  - WAIT_DONE: the timeout counter increments each cycle.
    - done_rise: go to GAP.
    - Counter reaches TIMEOUT_CYCLES-1: pulse timeout_err and go to GAP.
    - If done_rise and the timeout coincide, done wins and there is no error.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
  - A done_rise while in IDLE or GAP is ignored.
- Latency:
  - First pop occurs the cycle after a push into an empty idle FIFO. in_id is asserted 2 cycles after the accepting edge.
  - Minimum spacing between in_id pulses = frame time + GAP_CYCLES + 2.
- in_cmd changes only on an ISSUE edge.

Decomposition:
- Shared package arm_pkg:
  - ARM_ID_W = 8
  - ARM_ID_NONE = 8'h00
  - FSM state encoding (IDLE, ISSUE, WAIT_DONE, GAP)
  - the request struct typedef {id[7:0], cmd}
- One sub-module: arm_req_fifo, a synchronous FIFO with parameterized depth and width 9, exposing full, empty and count. The FSM, counters and edge detect stay in the top level.

Test Plan:
- Reset then a single push of id=8'h02, cmd=1 -> one in_id=8'h02 pulse 2 cycles after acceptance, then 0. in_cmd=1 and held. No second pulse until done_rise + 1000 cycles.
- Push 3 requests back-to-back: (02,1), (09,0), (02,0). Bench Arm model asserts Tx_Done 500 cycles after each issue. -> Three in_id pulses in order with spacing 500+1000+2 cycles. in_cmd follows 1,0,0. busy drops after the last GAP.
- Fill the FIFO with 4 requests while WAIT_DONE is stalled -> req_ready=0 and fifo_count=4. A 5th push is held off until the next pop. No entry is lost or reordered.
- Push id=8'h00 -> bad_id single pulse, fifo_count unchanged, no in_id pulse.
- Issue with no Tx_Done -> timeout_err pulses exactly TIMEOUT_CYCLES cycles after entering WAIT_DONE. The next queued request issues 1000 cycles later.
- Assert Rst during GAP with 2 queued requests -> next cycle fifo_count=0, in_cmd=0, busy=0. A late Tx_Done then causes no issue.
